// File: rtl/bit_logic_unit.sv
// bit_logic_unit: multi-cycle bitwise AND/OR/XOR/NOT, SLICE bits per clock.
// Ports:
//   clock   - rising-edge clock
//   clear_n - asynchronous active-low reset
//   start   - request, sampled while idle
//   op      - 00 AND, 01 OR, 10 XOR, 11 NOT in1
//   in1/in2 - operands, latched on acceptance
//   busy    - operation in progress
//   done    - one-cycle pulse when out is updated
//   out     - {N, Z, C=0, V=0, result}
module bit_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH+3:0] out
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a, b, res, full, mask, next_res;
    logic [1:0]       opr;
    logic [CW-1:0]    k;
    logic             last;

    // Whole-word result is formed combinationally; only slice k is committed each cycle.
    always_comb begin
        full     = opr == 2'b00 ? a & b : opr == 2'b01 ? a | b : opr == 2'b10 ? a ^ b : ~a;
        mask     = WIDTH'({SLICE{1'b1}}) << (int'(k) * SLICE);
        next_res = (res & ~mask) | (full & mask);
        last     = k == CW'(N - 1);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            opr   <= '0;
            k     <= '0;
            res   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a     <= in1;
                    b     <= in2;
                    opr   <= op;
                    k     <= '0;
                    res   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
            end else begin
                res <= next_res;
                k   <= last ? '0 : k + 1'b1;
                if (last) begin
                    out   <= {next_res[WIDTH-1], ~|next_res, 2'b00, next_res};
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end
endmodule
